// File: rtl/sdfm_sinc_channel.sv
// One SDFM demodulator channel: synchronizes a sigma-delta bitstream, runs a
// sinc1/2/3 CIC decimator and hands each word off with a DRDY/ACK/OVF handshake.
module sdfm_sinc_channel #(
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic          EXTCLK,
  input  logic          EXTRSTn,
  input  logic          SDCLK,
  input  logic          DSDIN,
  input  logic          EN,
  input  logic [1:0]    ORDER,
  input  logic [7:0]    OSR,
  input  logic          ACK,
  output logic [DW-1:0] DATA,
  output logic          DRDY,
  output logic          OVF
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] dsd_sync;
  logic                   sclk_d;
  logic                   sclk_s;
  logic                   dsd_s;
  logic                   bit_stb;

  logic                   en_d;
  logic                   en_rise;
  logic [1:0]             order_q;
  logic [7:0]             osr_q;
  logic [7:0]             osr_eff;

  logic                   stb_d;
  logic                   x_d;
  logic [7:0]             dec_cnt;
  logic                   dec_p1;
  logic                   dec_p2;
  logic [1:0]             settle_cnt;
  logic                   publish;

  logic [DW-1:0]          i1, i2, i3;
  logic [DW-1:0]          d1, d2, d3;
  logic [DW-1:0]          comb_in, c1, c2, c3, result;

  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      sclk_sync <= '0;
      dsd_sync  <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SDCLK};
      dsd_sync  <= {dsd_sync[SYNC_STAGES-2:0], DSDIN};
      sclk_d    <= sclk_s;
    end
  end

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign dsd_s   = dsd_sync[SYNC_STAGES-1];
  assign bit_stb = sclk_s & ~sclk_d;

  // A strobe landing on the enabling cycle itself must already see the new OSR.
  assign en_rise = EN & ~en_d;
  assign osr_eff = en_rise ? OSR : osr_q;

  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      en_d    <= 1'b0;
      order_q <= 2'd3;
      osr_q   <= '0;
    end else begin
      en_d <= EN;
      if (en_rise) begin
        order_q <= (ORDER == 2'd0) ? 2'd3 : ORDER;
        osr_q   <= OSR;
      end
    end
  end

  always_comb begin
    comb_in = i3;
    result  = c3;
    case (order_q)
      2'd1: begin comb_in = i1; result = c1; end
      2'd2: begin comb_in = i2; result = c2; end
      default: begin comb_in = i3; result = c3; end
    endcase
  end

  assign c1 = comb_in - d1;
  assign c2 = c1 - d2;
  assign c3 = c2 - d3;

  assign publish = EN & dec_p2 & (settle_cnt == order_q);

  // Filter datapath; dec_p2 lines up with the integrator holding the last bit.
  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      stb_d      <= 1'b0;
      x_d        <= 1'b0;
      dec_cnt    <= '0;
      dec_p1     <= 1'b0;
      dec_p2     <= 1'b0;
      settle_cnt <= '0;
      i1 <= '0; i2 <= '0; i3 <= '0;
      d1 <= '0; d2 <= '0; d3 <= '0;
    end else if (!EN) begin
      stb_d      <= 1'b0;
      x_d        <= 1'b0;
      dec_cnt    <= '0;
      dec_p1     <= 1'b0;
      dec_p2     <= 1'b0;
      settle_cnt <= '0;
      i1 <= '0; i2 <= '0; i3 <= '0;
      d1 <= '0; d2 <= '0; d3 <= '0;
    end else begin
      stb_d  <= bit_stb;
      x_d    <= dsd_s;
      dec_p1 <= bit_stb && (dec_cnt == osr_eff);
      dec_p2 <= dec_p1;
      if (bit_stb) begin
        dec_cnt <= (dec_cnt == osr_eff) ? 8'd0 : dec_cnt + 8'd1;
      end
      if (stb_d) begin
        i1 <= i1 + {{(DW-1){1'b0}}, x_d};
        i2 <= i2 + i1;
        i3 <= i3 + i2;
      end
      if (dec_p2) begin
        d1 <= comb_in;
        d2 <= c1;
        d3 <= c2;
        if (settle_cnt != order_q) begin
          settle_cnt <= settle_cnt + 2'd1;
        end
      end
    end
  end

  // Handshake stays live with EN low so a pending word can still be acknowledged.
  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      DATA <= '0;
      DRDY <= 1'b0;
      OVF  <= 1'b0;
    end else if (publish) begin
      DATA <= result;
      DRDY <= 1'b1;
      if (ACK) begin
        OVF <= 1'b0;
      end else if (DRDY) begin
        OVF <= 1'b1;
      end
    end else if (ACK && DRDY) begin
      DRDY <= 1'b0;
      OVF  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdfm_sinc_channel.sv
// Directed bench for sdfm_sinc_channel: SDCLK period is 8 EXTCLK cycles, so
// expected gains, word periods and strobe counts are computed by hand below.
module tb_sdfm_sinc_channel;

  logic        EXTCLK = 1'b0;
  logic        EXTRSTn = 1'b0;
  logic        SDCLK = 1'b0;
  logic        DSDIN = 1'b0;
  logic        EN = 1'b0;
  logic [1:0]  ORDER = 2'd1;
  logic [7:0]  OSR = 8'd0;
  logic        ACK = 1'b0;
  logic [31:0] DATA;
  logic        DRDY;
  logic        OVF;

  int    errors = 0;
  int    checks = 0;
  int    sd_rises = 0;
  int    dsd_mode = 1;
  int    base = 0;
  bit    got;
  bit    found;
  longint t0;

  sdfm_sinc_channel #(.DW(32), .SYNC_STAGES(2)) dut (
    .EXTCLK(EXTCLK), .EXTRSTn(EXTRSTn), .SDCLK(SDCLK), .DSDIN(DSDIN),
    .EN(EN), .ORDER(ORDER), .OSR(OSR), .ACK(ACK),
    .DATA(DATA), .DRDY(DRDY), .OVF(OVF)
  );

  always #5 EXTCLK = ~EXTCLK;

  // Modulator model: data changes on SDCLK fall, so it is stable at the rise.
  initial begin
    forever begin
      #40 SDCLK = ~SDCLK;
      if (SDCLK) sd_rises++;
      else begin
        case (dsd_mode)
          0: DSDIN = 1'b0;
          1: DSDIN = 1'b1;
          default: DSDIN = ~DSDIN;
        endcase
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge EXTCLK);
  endtask

  task automatic pulse_ack;
    @(negedge EXTCLK);
    ACK = 1'b1;
    @(negedge EXTCLK);
    ACK = 1'b0;
  endtask

  task automatic wait_word(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge EXTCLK);
      if (DRDY) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_stb(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge EXTCLK);
      if (dut.bit_stb) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic start(input logic [1:0] o, input logic [7:0] r, input int mode);
    EN = 1'b0;
    tick(4);
    if (DRDY) pulse_ack;
    dsd_mode = mode;
    ORDER = o;
    OSR = r;
    @(negedge SDCLK);
    EN = 1'b1;
    base = sd_rises;
  endtask

  task automatic test_reset;
    tick(3);
    checks++; if (DATA !== 32'd0) begin errors++; $display("[TB] FAIL reset_data got=%0d exp=0", DATA); end
    checks++; if (DRDY !== 1'b0) begin errors++; $display("[TB] FAIL reset_drdy got=%b exp=0", DRDY); end
    checks++; if (OVF !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got=%b exp=0", OVF); end
    EXTRSTn = 1'b1;
    tick(2);
  endtask

  task automatic test_order1_osr255;
    start(2'd1, 8'd255, 1);
    wait_word(6000, got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL o1_timeout got=0 exp=1"); end
    checks++; if (sd_rises - base !== 512) begin errors++; $display("[TB] FAIL o1_settle_bits got=%0d exp=512", sd_rises - base); end
    checks++; if (DATA !== 32'd256) begin errors++; $display("[TB] FAIL o1_data got=%0d exp=256", DATA); end
    pulse_ack;
    checks++; if (DRDY !== 1'b0) begin errors++; $display("[TB] FAIL o1_ack_drdy got=%b exp=0", DRDY); end
    wait_word(3000, got);
    checks++; if (!got || DATA !== 32'd256) begin errors++; $display("[TB] FAIL o1_next_data got=%0d ok=%b exp=256", DATA, got); end
    pulse_ack;
  endtask

  task automatic test_order3_settle;
    start(2'd3, 8'd3, 1);
    wait_word(400, got);
    checks++; if (!got || sd_rises - base !== 16) begin errors++; $display("[TB] FAIL o3_settle_bits got=%0d ok=%b exp=16", sd_rises - base, got); end
    checks++; if (DATA !== 32'd64) begin errors++; $display("[TB] FAIL o3_data got=%0d exp=64", DATA); end
    t0 = $time;
    pulse_ack;
    wait_word(100, got);
    checks++; if (!got || ($time - t0) !== 320) begin errors++; $display("[TB] FAIL o3_period got=%0d exp=320", $time - t0); end
    checks++; if (DATA !== 32'd64) begin errors++; $display("[TB] FAIL o3_data2 got=%0d exp=64", DATA); end
    pulse_ack;
  endtask

  task automatic test_patterns;
    start(2'd1, 8'd3, 2);
    for (int w = 0; w < 3; w++) begin
      wait_word(100, got);
      checks++; if (!got || DATA !== 32'd2) begin errors++; $display("[TB] FAIL alt_data word=%0d got=%0d ok=%b exp=2", w, DATA, got); end
      pulse_ack;
    end
    start(2'd2, 8'd15, 1);
    wait_word(600, got);
    checks++; if (!got || DATA !== 32'd256) begin errors++; $display("[TB] FAIL o2_ones got=%0d ok=%b exp=256", DATA, got); end
    checks++; if (sd_rises - base !== 48) begin errors++; $display("[TB] FAIL o2_settle_bits got=%0d exp=48", sd_rises - base); end
    start(2'd2, 8'd15, 0);
    wait_word(600, got);
    checks++; if (!got || DATA !== 32'd0) begin errors++; $display("[TB] FAIL o2_zeros got=%0d ok=%b exp=0", DATA, got); end
    pulse_ack;
  endtask

  task automatic test_latency;
    start(2'd1, 8'd0, 1);
    wait_word(100, got);
    pulse_ack;
    wait_stb(100, found);
    checks++; if (!found) begin errors++; $display("[TB] FAIL lat_stb_timeout got=0 exp=1"); end
    repeat (2) @(posedge EXTCLK);
    #1;
    checks++; if (DRDY !== 1'b0) begin errors++; $display("[TB] FAIL lat_early got=%b exp=0", DRDY); end
    @(posedge EXTCLK);
    #1;
    checks++; if (DRDY !== 1'b1 || DATA !== 32'd1) begin errors++; $display("[TB] FAIL lat_on_time drdy=%b data=%0d exp=1/1", DRDY, DATA); end
    pulse_ack;
  endtask

  task automatic test_overflow;
    start(2'd1, 8'd3, 1);
    wait_word(200, got);
    repeat (4) @(posedge SDCLK);
    tick(8);
    checks++; if (OVF !== 1'b1 || DRDY !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set ovf=%b drdy=%b exp=1/1", OVF, DRDY); end
    checks++; if (DATA !== 32'd4) begin errors++; $display("[TB] FAIL ovf_data got=%0d exp=4", DATA); end
    pulse_ack;
    checks++; if (DRDY !== 1'b0 || OVF !== 1'b0) begin errors++; $display("[TB] FAIL ovf_ack drdy=%b ovf=%b exp=0/0", DRDY, OVF); end
  endtask

  task automatic test_back_to_back;
    start(2'd1, 8'd0, 1);
    wait_word(100, got);
    pulse_ack;
    wait_word(100, got);
    wait_stb(100, found);
    @(posedge EXTCLK);
    @(posedge EXTCLK);
    @(negedge EXTCLK);
    ACK = 1'b1;
    @(negedge EXTCLK);
    ACK = 1'b0;
    checks++; if (!found || DRDY !== 1'b1 || OVF !== 1'b0) begin errors++; $display("[TB] FAIL ack_publish drdy=%b ovf=%b exp=1/0", DRDY, OVF); end
    pulse_ack;
  endtask

  task automatic test_osr_change;
    start(2'd1, 8'd3, 1);
    wait_word(200, got);
    pulse_ack;
    OSR = 8'd7;
    wait_word(100, got);
    t0 = $time;
    pulse_ack;
    wait_word(100, got);
    checks++; if (!got || ($time - t0) !== 320) begin errors++; $display("[TB] FAIL osr_ignored period=%0d exp=320", $time - t0); end
    checks++; if (DATA !== 32'd4) begin errors++; $display("[TB] FAIL osr_ignored_data got=%0d exp=4", DATA); end
    start(2'd1, 8'd7, 1);
    wait_word(300, got);
    checks++; if (!got || sd_rises - base !== 16) begin errors++; $display("[TB] FAIL osr_new_settle got=%0d exp=16", sd_rises - base); end
    checks++; if (DATA !== 32'd8) begin errors++; $display("[TB] FAIL osr_new_data got=%0d exp=8", DATA); end
  endtask

  task automatic test_reset_mid;
    tick(20);
    #3;
    EXTRSTn = 1'b0;
    #1;
    checks++; if (DATA !== 32'd0 || DRDY !== 1'b0 || OVF !== 1'b0) begin errors++; $display("[TB] FAIL async_reset data=%0d drdy=%b ovf=%b exp=0/0/0", DATA, DRDY, OVF); end
    EN = 1'b0;
    tick(3);
    EXTRSTn = 1'b1;
    start(2'd1, 8'd7, 1);
    wait_word(300, got);
    checks++; if (!got || sd_rises - base !== 16 || DATA !== 32'd8) begin errors++; $display("[TB] FAIL fresh_enable bits=%0d data=%0d exp=16/8", sd_rises - base, DATA); end
    pulse_ack;
  endtask

  initial begin
    test_reset;
    test_order1_osr255;
    test_order3_settle;
    test_patterns;
    test_latency;
    test_overflow;
    test_back_to_back;
    test_osr_change;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdfm_sinc_channel.md
Name: sdfm_sinc_channel

Overview:
- One demodulator channel of the SDFM. Consumes one sigma-delta modulator bitstream (DSDIN with its SDCLK), in the EXTCLK domain.
- Runs a configurable sinc1/sinc2/sinc3 CIC decimation filter and presents each decimated word with a ready/acknowledge handshake to the SDFM register and IRQ logic.
- Instantiated once per DSDIN/SDCLK bit pair.

Parameters:
- DW, 32, width of integrators, combs and DATA; modular (wrap-around) arithmetic.
- SYNC_STAGES, 2, synchronizer flip-flops on SDCLK and DSDIN (minimum 2).

Ports:
- EXTCLK  in  1  system clock; all logic on rising edge.
- EXTRSTn  in  1  asynchronous active-low reset.
- SDCLK  in  1  modulator clock, asynchronous to EXTCLK; frequency ≤ EXTCLK/4.
- DSDIN  in  1  modulator bitstream, valid at SDCLK rising edge.
- EN  in  1  channel enable.
- ORDER  in  2  filter order: 1, 2 or 3. Value 0 is treated as 3.
- OSR  in  8  oversampling ratio minus 1 (OSR=255 means 256 bits per output).
- ACK  in  1  one-cycle pulse: consumer has read DATA.
- DATA  out  DW  latest decimated word, unsigned.
- DRDY  out  1  level: unread word in DATA.
- OVF  out  1  sticky: a word was overwritten before ACK.

Behaviour:
- Reset (async, EXTRSTn=0): clears all synchronizers, integrators, combs and counters. Outputs: DATA=0, DRDY=0, OVF=0.
- Input capture:
  - SDCLK and DSDIN each pass through SYNC_STAGES flops, plus one extra flop on SDCLK for edge detection.
  - bit_stb is a one-cycle pulse on the EXTCLK cycle where the synced SDCLK rises. The sample taken is the synced DSDIN of that same cycle.
  - Bit mapping: 1 maps to +1, 0 maps to 0.
- Configuration: ORDER and OSR are latched on the EN 0→1 transition. Changes while EN=1 are ignored.
- EN=0:
  - Integrators, combs, decimation counter and settle counter are held at 0; bit_stb is ignored.
  - DATA keeps its last value. DRDY and OVF still respond to ACK.
- Integrators (pipelined, updated only on the cycle after bit_stb):
  - I1 += x; I2 += I1(old); I3 += I2(old).
  - Only the first ORDER stages are used; the last used stage feeds the comb.
- Decimation counter:
  - Counts bit_stb from 0 to OSR. On the strobe that matches OSR it wraps to 0 and schedules a decimation.
  - Decimation samples the last integrator 2 cycles after that strobe, then runs the ORDER comb stages: Cn = in - in_delayed.
  - The result is registered into DATA 3 EXTCLK cycles after the terminating bit_stb.
- Output gain:
  - Constant all-ones input settles to (OSR+1)^ORDER; all-zeros gives 0.
  - Results wrap modulo 2^DW; (OSR+1)^ORDER must fit in DW bits, which it does for DW=32 and all legal settings.
- Settling: after EN rises, the first ORDER decimated results are discarded (DATA and DRDY untouched). From decimation ORDER+1 onward every result is published.
- Handshake, on each published result (DATA updates):
  - DRDY=1 on the same cycle as the DATA update.
  - If DRDY was already 1 and no ACK arrives that cycle: OVF is set to 1.
  - ACK alone: DRDY is cleared to 0 and OVF is cleared to 0 on the next edge.
  - ACK and a publish on the same cycle: DRDY stays 1, OVF is not set (the ACK consumes the previous word), and DATA takes the new value.
  - ACK while DRDY=0: no effect.
- EN falling mid-window: the partial window is discarded and no result is published. Re-enabling restarts the window count and the settling count.
- Reset mid-operation: immediate return to reset state. The next EN rise is treated as a fresh enable.
- SDCLK stopped: no strobes, so the filter freezes. No timeout is required.

Test Plan:
- Reset, then EN=1, ORDER=1, OSR=255, DSDIN constant 1 -> first word discarded; DRDY rises with DATA=256. ACK -> DRDY=0. Next DATA=256.
- ORDER=3, OSR=3, DSDIN constant 1 -> first 3 decimations produce no DRDY; 4th and later give DATA=64, exactly 4 SDCLK periods apart.
- ORDER=1, OSR=3, DSDIN alternating 1010 -> DATA=2 every word. ORDER=2, OSR=15, all-ones -> settled DATA=256. All-zeros -> DATA=0.
- Latency: ORDER=1, OSR=0 -> DRDY/DATA update exactly 3 EXTCLK cycles after the bit_stb cycle. Bench probes bit_stb or uses the SDCLK edge plus 3 sync cycles.
- No ACK for two publishes -> OVF=1 and DATA=newest. ACK -> DRDY=0, OVF=0. ACK coincident with a publish -> DRDY=1, OVF stays 0.
- Change OSR while EN=1 -> period unchanged. EN toggled 0→1 -> new OSR applies and settling repeats. EXTRSTn pulsed mid-window -> DATA=0, DRDY=0, OVF=0 immediately (asynchronous).
